// File: rtl/branch_resolve_ctrl_pkg.sv
// branch_resolve_ctrl_pkg: shared branch type codes, flag indices and controller states
package branch_resolve_ctrl_pkg;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_JAL  = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam int ZERO  = 0;
  localparam int CARRY = 1;
  localparam int OVF   = 2;
  localparam int NEG   = 3;
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
endpackage

// File: rtl/branch_resolve_ctrl_cond_eval.sv
// branch_cond_eval: combinational taken decision from branch type and rs1-rs2 flags
module branch_cond_eval
  import branch_resolve_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [3:0] flags,
  output logic       taken
);
  logic lt;
  assign lt = flags[NEG] ^ flags[OVF];
  // Signed compares use N^V, unsigned compares use the borrow; jump codes never take here
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:          taken = flags[ZERO];
      F3_BNE:          taken = !flags[ZERO];
      F3_BLT:          taken = lt;
      F3_BGE:          taken = !lt;
      F3_BLTU:         taken = flags[CARRY];
      F3_BGEU:         taken = !flags[CARRY];
      F3_JAL, F3_JALR: taken = 1'b0;
      default:         taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: queues conditional branches and sequences flush/redirect on taken (BRANCH_STATS_EN adds taken_count)
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int FLUSH_CYCLES = 2
)(
  input  logic        clock,
  input  logic        reset,
  input  logic        br_issue_valid,
  input  logic [2:0]  br_issue_funct3,
  input  logic [31:0] br_issue_target,
  output logic        br_issue_ready,
  input  logic        alu_flags_valid,
  input  logic [3:0]  alu_flags,
  output logic        flush,
  output logic        fetch_hold,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
`ifdef BRANCH_STATS_EN
  output logic [31:0] taken_count,
`endif
  input  logic        redirect_ready
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  logic [2:0]    q_funct3 [DEPTH];
  logic [31:0]   q_target [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [FCW-1:0] fcnt, fcnt_n;
  state_t        state, state_n;
  logic          full, empty, push, pop, taken, resolve_taken;

  assign full           = count == CW'(DEPTH);
  assign empty          = count == '0;
  assign br_issue_ready = state == IDLE && !full && !reset;
  assign push           = br_issue_valid && br_issue_ready;
  assign pop            = state == IDLE && alu_flags_valid && !empty;
  assign resolve_taken  = pop && taken;

  branch_cond_eval u_eval (
    .funct3 (q_funct3[rptr]),
    .flags  (alu_flags),
    .taken  (taken)
  );

  // Branch payload storage; entries past the write pointer are don't-care
  always_ff @(posedge clock) begin
    if (push) begin
      q_funct3[wptr] <= br_issue_funct3;
      q_target[wptr] <= br_issue_target;
    end
  end

  // Queue pointers and occupancy; a taken resolve drops everything younger, including a same-cycle issue
  always_ff @(posedge clock) begin
    if (reset || resolve_taken) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= push ? wptr + AW'(1) : wptr;
      rptr  <= pop ? rptr + AW'(1) : rptr;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Next-state: taken resolve starts the flush countdown, redirect waits for the fetch handshake
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    case (state)
      IDLE: begin
        if (resolve_taken) begin
          state_n = FLUSH;
          fcnt_n  = FCW'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (fcnt == FCW'(1)) state_n = REDIRECT;
        else fcnt_n = fcnt - FCW'(1);
      end
      REDIRECT: state_n = redirect_ready ? IDLE : REDIRECT;
      default:  state_n = IDLE;
    endcase
  end

  // State and registered outputs decoded from the next state so they align with it
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      fcnt           <= '0;
      flush          <= 1'b0;
      fetch_hold     <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state          <= state_n;
      fcnt           <= fcnt_n;
      flush          <= state_n == FLUSH;
      fetch_hold     <= state_n != IDLE;
      redirect_valid <= state_n == REDIRECT;
      redirect_pc    <= resolve_taken ? q_target[rptr] : redirect_pc;
    end
  end

`ifdef BRANCH_STATS_EN
  // Taken-branch statistic, wraps naturally at 2^32
  always_ff @(posedge clock) begin
    if (reset) taken_count <= '0;
    else if (resolve_taken) taken_count <= taken_count + 32'd1;
  end
`endif
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed vector table plus randomized run against a queue-based reference model
module tb_branch_resolve_ctrl;
  localparam int DEPTH = 2;
  localparam int FC    = 2;

  logic        clock = 1'b0;
  logic        reset, br_issue_valid, alu_flags_valid, redirect_ready;
  logic [2:0]  br_issue_funct3;
  logic [31:0] br_issue_target;
  logic [3:0]  alu_flags;
  logic        br_issue_ready, flush, fetch_hold, redirect_valid;
  logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] taken_count;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  branch_resolve_ctrl #(.DEPTH(DEPTH), .FLUSH_CYCLES(FC)) dut (
    .clock           (clock),
    .reset           (reset),
    .br_issue_valid  (br_issue_valid),
    .br_issue_funct3 (br_issue_funct3),
    .br_issue_target (br_issue_target),
    .br_issue_ready  (br_issue_ready),
    .alu_flags_valid (alu_flags_valid),
    .alu_flags       (alu_flags),
    .flush           (flush),
    .fetch_hold      (fetch_hold),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
`ifdef BRANCH_STATS_EN
    .taken_count     (taken_count),
`endif
    .redirect_ready  (redirect_ready)
  );

  typedef struct {
    logic        rst, iv;
    logic [2:0]  f3;
    logic [31:0] tg;
    logic        afv;
    logic [3:0]  fl;
    logic        rr;
    logic        e_ready, e_flush, e_hold, e_rv;
    logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(logic rst, logic iv, logic [2:0] f3, logic [31:0] tg, logic afv,
                              logic [3:0] fl, logic rr, logic er, logic ef, logic eh, logic erv,
                              logic [31:0] epc);
    vec_t v;
    v.rst = rst; v.iv = iv; v.f3 = f3; v.tg = tg; v.afv = afv; v.fl = fl; v.rr = rr;
    v.e_ready = er; v.e_flush = ef; v.e_hold = eh; v.e_rv = erv; v.e_pc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  // Called #1 after a rising edge: drive, check comb ready, cross one edge, check registered outputs
  task automatic apply(input vec_t v, input int idx);
    reset = v.rst; br_issue_valid = v.iv; br_issue_funct3 = v.f3; br_issue_target = v.tg;
    alu_flags_valid = v.afv; alu_flags = v.fl; redirect_ready = v.rr;
    #1;
    chk("br_issue_ready", idx, 32'(br_issue_ready), 32'(v.e_ready));
    @(posedge clock);
    #1;
    chk("flush", idx, 32'(flush), 32'(v.e_flush));
    chk("fetch_hold", idx, 32'(fetch_hold), 32'(v.e_hold));
    chk("redirect_valid", idx, 32'(redirect_valid), 32'(v.e_rv));
    chk("redirect_pc", idx, redirect_pc, v.e_pc);
  endtask

  function automatic bit ref_taken(logic [2:0] f3, logic [3:0] fl);
    bit z = fl[0], c = fl[1], v = fl[2], n = fl[3];
    case (f3)
      3'b000: return z;
      3'b001: return !z;
      3'b100: return n != v;
      3'b101: return n == v;
      3'b110: return c;
      3'b111: return !c;
      default: return 1'b0;
    endcase
  endfunction

  logic [2:0]  mq_f3[$];
  logic [31:0] mq_tg[$];
  bit          m_busy;
  int          m_age;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  vec_t tbl[$];

  initial begin
    reset = 1'b1; br_issue_valid = 0; br_issue_funct3 = 0; br_issue_target = 0;
    alu_flags_valid = 0; alu_flags = 0; redirect_ready = 0;
    //        rst iv f3      tg            afv fl       rr   rdy fl ho rv pc
    tbl.push_back(mk(1, 0, 3'b000, 32'h0,        0, 4'b0000, 0,  0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 3'b000, 32'h100,      0, 4'b0000, 0,  1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        1, 4'b0001, 0,  1, 1, 1, 0, 32'h100));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        0, 4'b0000, 0,  0, 1, 1, 0, 32'h100));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        0, 4'b0000, 0,  0, 0, 1, 1, 32'h100));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        0, 4'b0000, 1,  0, 0, 0, 0, 32'h100));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        0, 4'b0000, 0,  1, 0, 0, 0, 32'h100));
    tbl.push_back(mk(0, 1, 3'b001, 32'h200,      0, 4'b0000, 0,  1, 0, 0, 0, 32'h100));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        1, 4'b0001, 0,  1, 0, 0, 0, 32'h100));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        1, 4'b0001, 0,  1, 0, 0, 0, 32'h100));
    tbl.push_back(mk(0, 1, 3'b100, 32'h300,      0, 4'b0000, 0,  1, 0, 0, 0, 32'h100));
    tbl.push_back(mk(0, 1, 3'b000, 32'h400,      0, 4'b0000, 0,  1, 0, 0, 0, 32'h100));
    tbl.push_back(mk(0, 1, 3'b000, 32'h500,      0, 4'b0000, 0,  0, 0, 0, 0, 32'h100));
    tbl.push_back(mk(0, 1, 3'b000, 32'h500,      1, 4'b1000, 0,  0, 1, 1, 0, 32'h300));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        0, 4'b0000, 1,  0, 1, 1, 0, 32'h300));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        0, 4'b0000, 1,  0, 0, 1, 1, 32'h300));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        0, 4'b0000, 1,  0, 0, 0, 0, 32'h300));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        1, 4'b0001, 0,  1, 0, 0, 0, 32'h300));
    tbl.push_back(mk(0, 1, 3'b101, 32'hDEADBEE0, 0, 4'b0000, 0,  1, 0, 0, 0, 32'h300));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        1, 4'b0000, 0,  1, 1, 1, 0, 32'hDEADBEE0));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        0, 4'b0000, 0,  0, 1, 1, 0, 32'hDEADBEE0));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        0, 4'b0000, 0,  0, 0, 1, 1, 32'hDEADBEE0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, i == 1, 3'b000, 32'h999, i == 2, 4'b0001, 0, 0, 0, 1, 1, 32'hDEADBEE0));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        0, 4'b0000, 1,  0, 0, 0, 0, 32'hDEADBEE0));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        1, 4'b0001, 0,  1, 0, 0, 0, 32'hDEADBEE0));
    tbl.push_back(mk(0, 1, 3'b000, 32'h600,      0, 4'b0000, 0,  1, 0, 0, 0, 32'hDEADBEE0));
    tbl.push_back(mk(0, 1, 3'b111, 32'h700,      1, 4'b0001, 0,  1, 1, 1, 0, 32'h600));
    tbl.push_back(mk(1, 0, 3'b000, 32'h0,        0, 4'b0000, 0,  0, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 3'b111, 32'h800,      0, 4'b0000, 0,  1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        1, 4'b0010, 0,  1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        1, 4'b0001, 0,  1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 3'b010, 32'h900,      0, 4'b0000, 0,  1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        1, 4'b0001, 0,  1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 3'b110, 32'hA00,      0, 4'b0000, 0,  1, 0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        1, 4'b0010, 1,  1, 1, 1, 0, 32'hA00));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        0, 4'b0000, 1,  0, 1, 1, 0, 32'hA00));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        0, 4'b0000, 1,  0, 0, 1, 1, 32'hA00));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        0, 4'b0000, 1,  0, 0, 0, 0, 32'hA00));
    tbl.push_back(mk(0, 0, 3'b000, 32'h0,        0, 4'b0000, 0,  1, 0, 0, 0, 32'hA00));

    @(posedge clock);
    #1;
    foreach (tbl[i]) apply(tbl[i], i);
`ifdef BRANCH_STATS_EN
    chk("taken_count_table", 0, taken_count, 32'd1);
`endif

    mq_f3.delete(); mq_tg.delete(); m_busy = 0; m_age = 0; m_pc = 0; m_cnt = 0;
    for (int c = 0; c < 2000; c++) begin
      vec_t v;
      bit pre_busy;
      int pre_age;
      v.rst = (c == 0) || ($urandom_range(0, 99) < 2);
      v.iv  = $urandom_range(0, 1);
      v.f3  = 3'($urandom_range(0, 7));
      v.tg  = $urandom & 32'hFFFF_FFFC;
      v.afv = $urandom_range(0, 9) < 4;
      v.fl  = 4'($urandom_range(0, 15));
      v.rr  = $urandom_range(0, 1);
      pre_busy = m_busy;
      pre_age  = m_age;
      v.e_ready = !v.rst && !m_busy && mq_f3.size() < DEPTH;
      if (v.rst) begin
        mq_f3.delete(); mq_tg.delete(); m_busy = 0; m_pc = 0; m_cnt = 0;
      end else if (pre_busy) begin
        if (pre_age > FC && v.rr) m_busy = 0;
        else m_age = pre_age + 1;
      end else if (v.afv && mq_f3.size() > 0 && ref_taken(mq_f3[0], v.fl)) begin
        m_pc = mq_tg[0]; mq_f3.delete(); mq_tg.delete(); m_busy = 1; m_age = 1; m_cnt++;
      end else begin
        if (v.afv && mq_f3.size() > 0) begin
          void'(mq_f3.pop_front()); void'(mq_tg.pop_front());
        end
        if (v.iv && v.e_ready) begin
          mq_f3.push_back(v.f3); mq_tg.push_back(v.tg);
        end
      end
      v.e_flush = m_busy && m_age <= FC;
      v.e_rv    = m_busy && m_age > FC;
      v.e_hold  = m_busy;
      v.e_pc    = m_pc;
      apply(v, 1000 + c);
`ifdef BRANCH_STATS_EN
      chk("taken_count", 1000 + c, taken_count, m_cnt);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
